// File: rtl/saturn_inst_decoder_nib_pkg.sv
// rtl/saturn_inst_decoder_nib_pkg.sv - ALU register/op codes, instruction classes and decoder states
package saturn_inst_decoder_nib_pkg;

  localparam logic [4:0] ALU_REG_A    = 5'd0;
  localparam logic [4:0] ALU_REG_B    = 5'd1;
  localparam logic [4:0] ALU_REG_C    = 5'd2;
  localparam logic [4:0] ALU_REG_D    = 5'd3;
  localparam logic [4:0] ALU_REG_P    = 5'd16;
  localparam logic [4:0] ALU_REG_IMM  = 5'd30;
  localparam logic [4:0] ALU_REG_NONE = 5'd31;

  localparam logic [4:0] ALU_OP_NOP   = 5'd0;
  localparam logic [4:0] ALU_OP_COPY  = 5'd1;

  localparam logic [3:0] INSTR_TYPE_ALU    = 4'd0;
  localparam logic [3:0] INSTR_TYPE_LOAD   = 4'd1;
  localparam logic [3:0] INSTR_TYPE_GOTO   = 4'd2;
  localparam logic [3:0] INSTR_TYPE_GOSUB  = 4'd3;
  localparam logic [3:0] INSTR_TYPE_GOVLNG = 4'd4;
  localparam logic [3:0] INSTR_TYPE_GOSBVL = 4'd5;
  localparam logic [3:0] INSTR_TYPE_RTN    = 4'd6;
  localparam logic [3:0] INSTR_TYPE_NONE   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLK0,
    S_BLK2,
    S_BLK3_LEN,
    S_IMM,
    S_REL3,
    S_BLK8,
    S_ABS5
  } dec_state_t;

endpackage

// File: rtl/saturn_nibble_accum.sv
// rtl/saturn_nibble_accum.sv - nibble accumulator: each loaded nibble lands in the slot given by its counter
module saturn_nibble_accum #(
  parameter int NIBBLES = 16,
  parameter int CNT_W   = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [3:0]           i_nibble,
  output logic [4*NIBBLES-1:0] o_value_next,
  output logic [CNT_W-1:0]     o_count
);

  logic [4*NIBBLES-1:0] value;

  // Value as it will be once the current nibble is stored; lets the decoder
  // publish the final nibble in the same cycle it is accepted.
  always_comb begin
    o_value_next = value;
    for (int k = 0; k < NIBBLES; k++) begin
      if (o_count == CNT_W'(k)) o_value_next[4*k +: 4] = i_nibble;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      value   <= '0;
      o_count <= '0;
    end else if (i_clear) begin
      value   <= '0;
      o_count <= '0;
    end else if (i_load) begin
      value   <= o_value_next;
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/saturn_inst_decoder_nib.sv
// rtl/saturn_inst_decoder_nib.sv - multi-nibble Saturn decoder (0x, 2n, 3n, 6xxx/7xxx, 8D/8F)
// Long-jump decode (8D/8F) is compiled in only with SATURN_DEC_LONG_JUMP_EN defined.
module saturn_inst_decoder_nib
  import saturn_inst_decoder_nib_pkg::*;
#(
  parameter int IMM_NIBBLES = 16,
  parameter int ADDR_W      = 20
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_debug_cycle,
  input  logic                     i_bus_busy,
  input  logic                     i_nibble_valid,
  input  logic [3:0]               i_nibble,
  input  logic [ADDR_W-1:0]        i_pc,
  output logic [4:0]               o_alu_reg_dest,
  output logic [4:0]               o_alu_reg_src_1,
  output logic [4:0]               o_alu_reg_src_2,
  output logic [4:0]               o_alu_opcode,
  output logic [4*IMM_NIBBLES-1:0] o_imm_value,
  output logic [3:0]               o_imm_len,
  output logic [ADDR_W-1:0]        o_jump_offset,
  output logic [3:0]               o_instr_type,
  output logic                     o_instr_decoded,
  output logic                     o_illegal,
  output logic                     o_decoding,
  output logic [ADDR_W-1:0]        o_dbg_inst_addr
);

  localparam int IMM_W       = 4 * IMM_NIBBLES;
  localparam int ACC_NIBBLES = (IMM_NIBBLES > 5) ? IMM_NIBBLES : 5;

  dec_state_t                 state;
  logic                       accept;
  logic                       is_sub;
  logic [3:0]                 imm_len_q;
  logic                       acc_clear;
  logic                       acc_load;
  logic [4*ACC_NIBBLES-1:0]   acc_next;
  logic [4:0]                 acc_count;

  assign accept     = i_nibble_valid && !i_bus_busy && !i_debug_cycle;
  assign o_decoding = (state != S_IDLE);
  assign acc_clear  = accept && (state == S_IDLE || state == S_BLK3_LEN || state == S_BLK8);
  assign acc_load   = accept && (state == S_IMM || state == S_REL3 || state == S_ABS5);

  saturn_nibble_accum #(
    .NIBBLES (ACC_NIBBLES),
    .CNT_W   (5)
  ) u_accum (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (acc_clear),
    .i_load       (acc_load),
    .i_nibble     (i_nibble),
    .o_value_next (acc_next),
    .o_count      (acc_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state           <= S_IDLE;
      is_sub          <= 1'b0;
      imm_len_q       <= '0;
      o_alu_reg_dest  <= ALU_REG_NONE;
      o_alu_reg_src_1 <= ALU_REG_NONE;
      o_alu_reg_src_2 <= ALU_REG_NONE;
      o_alu_opcode    <= ALU_OP_NOP;
      o_imm_value     <= '0;
      o_imm_len       <= '0;
      o_jump_offset   <= '0;
      o_instr_type    <= INSTR_TYPE_NONE;
      o_instr_decoded <= 1'b0;
      o_illegal       <= 1'b0;
      o_dbg_inst_addr <= '0;
    end else begin
      o_instr_decoded <= 1'b0;
      o_illegal       <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            o_dbg_inst_addr <= i_pc;
            case (i_nibble)
              4'h0: state <= S_BLK0;
              4'h2: state <= S_BLK2;
              4'h3: state <= S_BLK3_LEN;
              4'h6, 4'h7: begin
                state  <= S_REL3;
                is_sub <= i_nibble[0];
              end
`ifdef SATURN_DEC_LONG_JUMP_EN
              4'h8: state <= S_BLK8;
`endif
              default: o_illegal <= 1'b1;
            endcase
          end
          S_BLK0: begin
            state <= S_IDLE;
            if (i_nibble <= 4'h3) begin
              o_alu_reg_dest  <= ALU_REG_NONE;
              o_alu_reg_src_1 <= ALU_REG_NONE;
              o_alu_reg_src_2 <= ALU_REG_NONE;
              o_alu_opcode    <= ALU_OP_NOP;
              o_imm_value     <= IMM_W'(i_nibble);
              o_imm_len       <= '0;
              o_instr_type    <= INSTR_TYPE_RTN;
              o_instr_decoded <= 1'b1;
            end else begin
              o_illegal <= 1'b1;
            end
          end
          S_BLK2: begin
            state           <= S_IDLE;
            o_alu_reg_dest  <= ALU_REG_P;
            o_alu_reg_src_1 <= ALU_REG_IMM;
            o_alu_reg_src_2 <= ALU_REG_NONE;
            o_alu_opcode    <= ALU_OP_COPY;
            o_imm_value     <= IMM_W'(i_nibble);
            o_imm_len       <= '0;
            o_instr_type    <= INSTR_TYPE_ALU;
            o_instr_decoded <= 1'b1;
          end
          S_BLK3_LEN: begin
            imm_len_q <= i_nibble;
            state     <= S_IMM;
          end
          S_IMM: begin
            if (acc_count == {1'b0, imm_len_q}) begin
              state           <= S_IDLE;
              o_alu_reg_dest  <= ALU_REG_C;
              o_alu_reg_src_1 <= ALU_REG_IMM;
              o_alu_reg_src_2 <= ALU_REG_NONE;
              o_alu_opcode    <= ALU_OP_COPY;
              o_imm_value     <= acc_next[IMM_W-1:0];
              o_imm_len       <= imm_len_q;
              o_instr_type    <= INSTR_TYPE_LOAD;
              o_instr_decoded <= 1'b1;
            end
          end
          S_REL3: begin
            if (acc_count == 5'd2) begin
              state           <= S_IDLE;
              o_alu_reg_dest  <= ALU_REG_NONE;
              o_alu_reg_src_1 <= ALU_REG_NONE;
              o_alu_reg_src_2 <= ALU_REG_NONE;
              o_alu_opcode    <= ALU_OP_NOP;
              o_jump_offset   <= ADDR_W'($signed(acc_next[11:0]));
              o_instr_type    <= is_sub ? INSTR_TYPE_GOSUB : INSTR_TYPE_GOTO;
              o_instr_decoded <= 1'b1;
            end
          end
`ifdef SATURN_DEC_LONG_JUMP_EN
          S_BLK8: begin
            if (i_nibble == 4'hD || i_nibble == 4'hF) begin
              state  <= S_ABS5;
              is_sub <= (i_nibble == 4'hF);
            end else begin
              state     <= S_IDLE;
              o_illegal <= 1'b1;
            end
          end
          S_ABS5: begin
            if (acc_count == 5'd4) begin
              state           <= S_IDLE;
              o_alu_reg_dest  <= ALU_REG_NONE;
              o_alu_reg_src_1 <= ALU_REG_NONE;
              o_alu_reg_src_2 <= ALU_REG_NONE;
              o_alu_opcode    <= ALU_OP_NOP;
              o_jump_offset   <= ADDR_W'(acc_next[19:0]);
              o_instr_type    <= is_sub ? INSTR_TYPE_GOSBVL : INSTR_TYPE_GOVLNG;
              o_instr_decoded <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_saturn_inst_decoder_nib.sv
// tb/tb_saturn_inst_decoder_nib.sv - scoreboard bench for saturn_inst_decoder_nib
module tb_saturn_inst_decoder_nib;
  import saturn_inst_decoder_nib_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        debug_cycle = 1'b0;
  logic        bus_busy = 1'b0;
  logic        nib_valid = 1'b0;
  logic [3:0]  nib = 4'h0;
  logic [19:0] pc_in = '0;
  logic [4:0]  alu_dest, alu_src1, alu_src2, alu_op;
  logic [63:0] imm_value;
  logic [3:0]  imm_len;
  logic [19:0] jump_offset;
  logic [3:0]  instr_type;
  logic        instr_decoded, illegal, decoding;
  logic [19:0] dbg_addr;

  always #5 clk = ~clk;

  saturn_inst_decoder_nib #(.IMM_NIBBLES(16), .ADDR_W(20)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_debug_cycle   (debug_cycle),
    .i_bus_busy      (bus_busy),
    .i_nibble_valid  (nib_valid),
    .i_nibble        (nib),
    .i_pc            (pc_in),
    .o_alu_reg_dest  (alu_dest),
    .o_alu_reg_src_1 (alu_src1),
    .o_alu_reg_src_2 (alu_src2),
    .o_alu_opcode    (alu_op),
    .o_imm_value     (imm_value),
    .o_imm_len       (imm_len),
    .o_jump_offset   (jump_offset),
    .o_instr_type    (instr_type),
    .o_instr_decoded (instr_decoded),
    .o_illegal       (illegal),
    .o_decoding      (decoding),
    .o_dbg_inst_addr (dbg_addr)
  );

  typedef struct {
    logic        ill;
    logic [3:0]  typ;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  op;
    logic [63:0] imm;
    logic [3:0]  len;
    logic [19:0] off;
    logic [19:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [19:0] pc = 20'h00100;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic ill, input logic [3:0] typ, input logic [19:0] pc0);
    exp_t r;
    r.ill = ill; r.typ = typ; r.pc = pc0;
    r.dest = ALU_REG_NONE; r.src1 = ALU_REG_NONE; r.op = ALU_OP_NOP;
    r.imm = '0; r.len = '0; r.off = '0;
    return r;
  endfunction

  function automatic exp_t mk_alu(input logic [3:0] typ, input logic [4:0] dest,
                                  input logic [63:0] imm, input logic [3:0] len, input logic [19:0] pc0);
    exp_t r;
    r = mk(1'b0, typ, pc0);
    r.dest = dest; r.src1 = ALU_REG_IMM; r.op = ALU_OP_COPY; r.imm = imm; r.len = len;
    return r;
  endfunction

  function automatic exp_t mk_jmp(input logic [3:0] typ, input logic [19:0] off, input logic [19:0] pc0);
    exp_t r;
    r = mk(1'b0, typ, pc0);
    r.off = off;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (instr_decoded || illegal) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {62'd0, illegal, instr_decoded}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("illegal", illegal, e.ill);
        check("decoded", instr_decoded, !e.ill);
        check("inst_addr", dbg_addr, e.pc);
        if (!e.ill) begin
          check("type", instr_type, e.typ);
          case (e.typ)
            INSTR_TYPE_ALU, INSTR_TYPE_LOAD: begin
              check("dest", alu_dest, e.dest);
              check("src1", alu_src1, e.src1);
              check("src2", alu_src2, ALU_REG_NONE);
              check("opcode", alu_op, e.op);
              check("imm", imm_value, e.imm);
              check("imm_len", imm_len, e.len);
            end
            INSTR_TYPE_RTN: begin
              check("rtn_opcode", alu_op, ALU_OP_NOP);
              check("rtn_imm", imm_value[3:0], e.imm[3:0]);
            end
            default: check("offset", jump_offset, e.off);
          endcase
        end
      end
    end
  end

  task automatic send(input logic [3:0] n);
    nib_valid = 1'b1; nib = n; pc_in = pc;
    @(posedge clk); #1;
    nib_valid = 1'b0; pc = pc + 1;
  endtask

  // Present a nibble while a stall source is held for some cycles, then let it through.
  task automatic send_stalled(input logic [3:0] n, input int cycles, input logic dbg);
    nib_valid = 1'b1; nib = n; pc_in = pc;
    if (dbg) debug_cycle = 1'b1; else bus_busy = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    check("decoding_in_stall", decoding, 1'b1);
    debug_cycle = 1'b0; bus_busy = 1'b0;
    @(posedge clk); #1;
    nib_valid = 1'b0; pc = pc + 1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check(tag, sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dest"}, alu_dest, ALU_REG_NONE);
    check({tag, "_src1"}, alu_src1, ALU_REG_NONE);
    check({tag, "_src2"}, alu_src2, ALU_REG_NONE);
    check({tag, "_op"}, alu_op, ALU_OP_NOP);
    check({tag, "_imm"}, imm_value, 64'd0);
    check({tag, "_len"}, imm_len, 4'd0);
    check({tag, "_off"}, jump_offset, 20'd0);
    check({tag, "_type"}, instr_type, 4'd15);
    check({tag, "_strobes"}, {instr_decoded, illegal}, 2'b00);
    check({tag, "_decoding"}, decoding, 1'b0);
    check({tag, "_addr"}, dbg_addr, 20'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] p0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_ALU, ALU_REG_P, 64'h5, 4'd0, p0));
    send(4'h2); send(4'h5);

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_LOAD, ALU_REG_C, 64'hCBA, 4'd2, p0));
    send(4'h3); send(4'h2); send(4'hA); send(4'hB); send(4'hC);

    p0 = pc; sb.push_back(mk_jmp(INSTR_TYPE_GOTO, 20'hFFFFF, p0));
    send(4'h6); send(4'hF); send_stalled(4'hF, 2, 1'b1); send(4'hF);

    p0 = pc; sb.push_back(mk_jmp(INSTR_TYPE_GOSUB, 20'h00001, p0));
    send(4'h7); send(4'h1); send(4'h0); send(4'h0);
    wait_drain("drain_rel");

`ifdef SATURN_DEC_LONG_JUMP_EN
    p0 = pc; sb.push_back(mk_jmp(INSTR_TYPE_GOVLNG, 20'h12345, p0));
    send(4'h8); send(4'hD); send(4'h5); send(4'h4);
    send_stalled(4'h3, 3, 1'b0);
    send(4'h2); send(4'h1);
`else
    p0 = pc; sb.push_back(mk(1'b1, INSTR_TYPE_NONE, p0));
    send(4'h8);
    @(posedge clk); #1;
    check("idle_after_8", decoding, 1'b0);
`endif
    wait_drain("drain_long");

    p0 = pc; sb.push_back(mk(1'b1, INSTR_TYPE_NONE, p0));
    send(4'h0); send(4'h7);
    p0 = pc; sb.push_back(mk(1'b0, INSTR_TYPE_RTN, p0)); sb[$].imm = 64'h1;
    send(4'h0); send(4'h1);
    p0 = pc; sb.push_back(mk(1'b1, INSTR_TYPE_NONE, p0));
    send(4'h5);

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_LOAD, ALU_REG_C, 64'h9, 4'd0, p0));
    send(4'h3); send(4'h0); send(4'h9);

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_LOAD, ALU_REG_C, 64'hFEDCBA9876543210, 4'hF, p0));
    send(4'h3); send(4'hF);
    for (int i = 0; i < 16; i++) send(4'(i));

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_ALU, ALU_REG_P, 64'hF, 4'd0, p0));
    send(4'h2); send(4'hF);
    wait_drain("drain_misc");

    send(4'h3); send(4'hF); send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    check("decoding_before_reset", decoding, 1'b1);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    check_reset_vals("mid_reset");
    repeat (3) begin @(posedge clk); #1; end
    check("no_strobe_after_reset", {instr_decoded, illegal}, 2'b00);

    p0 = pc; sb.push_back(mk_alu(INSTR_TYPE_ALU, ALU_REG_P, 64'h0, 4'd0, p0));
    send(4'h2); send(4'h0);
    wait_drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
